// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI register-access initiator.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam int FRAME_W     = 16;
    localparam int CMD_RW_BIT  = 15;
    localparam int DEF_CLK_DIV = 4;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_DATA_W  = 8;

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period timer: tick_o pulses on the last cycle of every CLK_DIV-cycle window while en_i is high.
// phase_o toggles on each tick; both counter and phase clear whenever en_i drops.
module spi_sclk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o,
    output logic phase_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic          phase_q;

    assign tick_o  = en_i && (cnt_q == CW'(CLK_DIV - 1));
    assign phase_o = phase_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (tick_o) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator: one 16-bit {cmd, data} frame per accepted command, done pulse 34H+1 cycles after accept.
// start_ready is high only in IDLE; commands offered at any other time simply wait.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              busy,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    state_t              state_q;
    logic [FRAME_W-2:0]  tx_q;
    logic [DATA_W-1:0]   rx_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [4:0]          bit_q;
    logic                rw_q;
    logic                done_q;
    logic                busy_q;
    logic                sclk_q;
    logic                cs_n_q;
    logic                mosi_q;

    logic [7:0]          cmd_d;
    logic [FRAME_W-1:0]  frame_d;
    logic                tick;
    logic                phase;
    logic                div_en;

    always_comb begin
        cmd_d             = '0;
        cmd_d[7]          = rw;
        cmd_d[ADDR_W-1:0] = addr;
        frame_d           = {cmd_d, (rw ? wdata : {DATA_W{1'b0}})};
    end

    // Timer is frozen for the done cycle so GAP still lasts a full H after it.
    assign div_en = (state_q != IDLE) && !done_q;

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (div_en),
        .tick_o  (tick),
        .phase_o (phase)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            bit_q   <= '0;
            rw_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        state_q <= SETUP;
                        tx_q    <= frame_d[FRAME_W-2:0];
                        mosi_q  <= frame_d[CMD_RW_BIT];
                        rw_q    <= rw;
                        bit_q   <= '0;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state_q <= SHIFT;
                        sclk_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    // phase tracks sclk here: 1 means the high phase is ending.
                    if (tick) begin
                        if (phase) begin
                            sclk_q <= 1'b0;
                            rx_q   <= {rx_q[DATA_W-2:0], miso};
                            bit_q  <= bit_q + 5'd1;
                            if (bit_q != 5'd15) begin
                                tx_q   <= {tx_q[FRAME_W-3:0], 1'b0};
                                mosi_q <= tx_q[FRAME_W-2];
                            end else begin
                                mosi_q <= 1'b0;
                            end
                        end else if (bit_q == 5'd16) begin
                            state_q <= HOLD;
                        end else begin
                            sclk_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state_q <= GAP;
                        cs_n_q  <= 1'b1;
                        done_q  <= 1'b1;
                        if (!rw_q) begin
                            rdata_q <= rx_q;
                        end
                    end
                end
                GAP: begin
                    busy_q <= 1'b0;
                    if (tick) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign rdata       = rdata_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign sclk        = sclk_q;
    assign cs_n        = cs_n_q;
    assign mosi        = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: two instances (H=4 and H=2), each with a memory-backed mode-0 target model.
module tb_spi_master;

    localparam int H0 = 4;
    localparam int H1 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] start_valid, start_ready, rw, done, busy, sclk, cs_n, mosi, miso;
    logic [3:0] addr  [2];
    logic [7:0] wdata [2];
    logic [7:0] rdata [2];

    logic [7:0]  mem      [2][16];
    bit   [15:0] mosi_cap [2];
    bit   [7:0]  rd_sh    [2];
    bit          sclk_prev[2];
    bit          cs_prev  [2];
    int nbits[2], acc_cyc[2], acc_delta[2], lat[2], csn_low[2], csn_snap[2];
    int rise_cur[2], rise_snap[2], last_rise[2], sclk_per[2], sclk_bad[2];
    int done_cnt[2], rdy_cnt[2], rdy_snap[2];
    int cyc = 0;
    int n_pass = 0, n_fail = 0, n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        spi_master #(.CLK_DIV((g == 0) ? H0 : H1)) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start_valid (start_valid[g]),
            .start_ready (start_ready[g]),
            .rw          (rw[g]),
            .addr        (addr[g]),
            .wdata       (wdata[g]),
            .rdata       (rdata[g]),
            .done        (done[g]),
            .busy        (busy[g]),
            .sclk        (sclk[g]),
            .cs_n        (cs_n[g]),
            .mosi        (mosi[g]),
            .miso        (miso[g])
        );
    end

    // Target model plus frame monitor; everything sampled half a cycle after the DUT edge.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (cs_n[g]) begin
                if (!cs_prev[g] && nbits[g] == 16 && mosi_cap[g][15])
                    mem[g][mosi_cap[g][11:8]] <= mosi_cap[g][7:0];
                nbits[g] <= 0;
                if (sclk[g]) sclk_bad[g] <= sclk_bad[g] + 1;
            end else begin
                csn_low[g] <= csn_low[g] + 1;
                if (sclk[g] && !sclk_prev[g]) begin
                    mosi_cap[g] <= {mosi_cap[g][14:0], mosi[g]};
                    nbits[g]    <= nbits[g] + 1;
                    rise_cur[g] <= rise_cur[g] + 1;
                    if (rise_cur[g] > 0) sclk_per[g] <= cyc - last_rise[g];
                    last_rise[g] <= cyc;
                end
                if (!sclk[g] && sclk_prev[g]) begin
                    if (nbits[g] == 8) begin
                        miso[g]  <= mem[g][mosi_cap[g][3:0]][7];
                        rd_sh[g] <= {mem[g][mosi_cap[g][3:0]][6:0], 1'b0};
                    end else if (nbits[g] > 8 && nbits[g] < 16) begin
                        miso[g]  <= rd_sh[g][7];
                        rd_sh[g] <= {rd_sh[g][6:0], 1'b0};
                    end
                end
            end
            if (rst_n && start_valid[g] && start_ready[g]) begin
                acc_delta[g] <= cyc - acc_cyc[g];
                acc_cyc[g]   <= cyc;
                rdy_snap[g]  <= rdy_cnt[g];
                rdy_cnt[g]   <= 0;
                csn_low[g]   <= 0;
                rise_cur[g]  <= 0;
            end else if (start_ready[g]) begin
                rdy_cnt[g] <= rdy_cnt[g] + 1;
            end
            if (done[g]) begin
                done_cnt[g]  <= done_cnt[g] + 1;
                lat[g]       <= cyc - acc_cyc[g];
                csn_snap[g]  <= csn_low[g];
                rise_snap[g] <= rise_cur[g];
            end
            sclk_prev[g] <= sclk[g];
            cs_prev[g]   <= cs_n[g];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (start_ready[i]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (done[i]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic run_cmd(input int i, input logic r, input logic [3:0] a, input logic [7:0] d);
        bit ok1, ok2;
        @(posedge clk); #1;
        start_valid[i] = 1'b1; rw[i] = r; addr[i] = a; wdata[i] = d;
        wait_ready(i, ok1);
        @(posedge clk); #1;
        start_valid[i] = 1'b0;
        wait_done(i, ok2);
        check("cmd_completes", {ok1, ok2}, 2'b11);
        idle(12);
    endtask

    initial begin
        bit ok;
        int d0;
        rst_n = 1'b0;
        start_valid = '0; rw = '0; miso <= '0;
        for (int g = 0; g < 2; g++) begin
            addr[g] = '0; wdata[g] = '0;
            for (int a = 0; a < 16; a++) mem[g][a] <= 8'h00;
        end
        idle(3); #1;
        mem[0][3] <= 8'hC3;
        mem[1][9] <= 8'h81;

        check("rst_cs_n", cs_n[0], 1'b1);
        check("rst_sclk", sclk[0], 1'b0);
        check("rst_mosi", mosi[0], 1'b0);
        check("rst_done", done[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        check("rst_rdata", rdata[0], 8'h00);
        check("rst_ready", start_ready[0], 1'b1);
        rst_n = 1'b1;

        // Write A <- 5C
        run_cmd(0, 1'b1, 4'hA, 8'h5C);
        check("wr_mosi_stream", mosi_cap[0], 16'h8A5C);
        check("wr_sclk_rises", rise_snap[0], 16);
        check("wr_cs_low_cycles", csn_snap[0], 34 * H0);
        check("wr_accept_to_done", lat[0], 34 * H0 + 1);
        check("wr_rdata_unchanged", rdata[0], 8'h00);
        check("wr_target_mem", mem[0][10], 8'h5C);
        check("wr_sclk_period", sclk_per[0], 2 * H0);
        check("wr_busy_after", busy[0], 1'b0);
        check("wr_done_count", done_cnt[0], 1);

        // Read 3 -> C3
        run_cmd(0, 1'b0, 4'h3, 8'hEE);
        check("rd_mosi_stream", mosi_cap[0], 16'h0300);
        check("rd_rdata", rdata[0], 8'hC3);
        check("rd_accept_to_done", lat[0], 34 * H0 + 1);

        // Round trip through address 0
        run_cmd(0, 1'b1, 4'h0, 8'hFF);
        check("rt_wr_rdata_kept", rdata[0], 8'hC3);
        run_cmd(0, 1'b0, 4'h0, 8'h00);
        check("rt_rdata", rdata[0], 8'hFF);
        check("rt_done_count", done_cnt[0], 4);

        // Back-to-back: fields change right after the first accept
        @(posedge clk); #1;
        start_valid[0] = 1'b1; rw[0] = 1'b1; addr[0] = 4'h5; wdata[0] = 8'h3C;
        wait_ready(0, ok);
        check("b2b_first_ready", ok, 1'b1);
        @(posedge clk); #1;
        rw[0] = 1'b0; addr[0] = 4'h5; wdata[0] = 8'h99;
        wait_ready(0, ok);
        check("b2b_second_ready", ok, 1'b1);
        @(posedge clk); #1;
        start_valid[0] = 1'b0;
        wait_done(0, ok);
        check("b2b_second_done", ok, 1'b1);
        idle(12);
        check("b2b_accept_spacing", acc_delta[0], 35 * H0 + 2);
        check("b2b_ready_while_busy", rdy_snap[0], 0);
        check("b2b_mem_first_value", mem[0][5], 8'h3C);
        check("b2b_rdata", rdata[0], 8'h3C);

        // Reset during the 6th bit period
        @(posedge clk); #1;
        start_valid[0] = 1'b1; rw[0] = 1'b1; addr[0] = 4'h7; wdata[0] = 8'hAA;
        wait_ready(0, ok);
        @(posedge clk); #1;
        start_valid[0] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            if (rise_cur[0] >= 6) begin
                ok = 1'b1;
                break;
            end
        end
        check("mid_reach_bit5", ok, 1'b1);
        #1 rst_n = 1'b0;
        d0 = done_cnt[0];
        @(posedge clk); #1;
        check("mid_cs_n", cs_n[0], 1'b1);
        check("mid_sclk", sclk[0], 1'b0);
        check("mid_mosi", mosi[0], 1'b0);
        check("mid_busy", busy[0], 1'b0);
        check("mid_ready", start_ready[0], 1'b1);
        check("mid_rdata", rdata[0], 8'h00);
        rst_n = 1'b1;
        idle(200);
        check("mid_no_done", done_cnt[0], d0);
        check("mid_no_write", mem[0][7], 8'h00);
        check("mid_stays_idle", cs_n[0], 1'b1);

        // Fastest divider
        run_cmd(1, 1'b0, 4'h9, 8'h00);
        check("div2_rdata", rdata[1], 8'h81);
        check("div2_mosi_stream", mosi_cap[1], 16'h0900);
        check("div2_cs_low_cycles", csn_snap[1], 34 * H1);
        check("div2_accept_to_done", lat[1], 34 * H1 + 1);
        check("div2_sclk_period", sclk_per[1], 2 * H1);
        check("div2_sclk_rises", rise_snap[1], 16);

        check("sclk_quiet_cs_high_0", sclk_bad[0], 0);
        check("sclk_quiet_cs_high_1", sclk_bad[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI initiator (mode 0: CPOL=0, CPHA=0) that issues single-register read/write frames to the team's 16x8 SPI register-memory target.
- Sits between a local bus controller, which uses a valid/ready command handshake, and the SPI pins.
- Each transaction is one 16-bit frame: a command byte followed by a data byte, MSB first.
- Read data is captured from MISO and returned with a one-cycle done pulse.

Parameters:
- CLK_DIV, 4, SCLK half-period in clk cycles (H). Legal range is 2 or more; SCLK frequency = f_clk / (2*CLK_DIV).
- ADDR_W, 4, address width; command byte is {rw, zero pad, addr}.
- DATA_W, 8, data byte width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start_valid  in  1  command request.
- start_ready  out  1  block idle and able to accept a command.
- rw  in  1  1 = write, 0 = read; sampled on accept.
- addr  in  ADDR_W  target register address; sampled on accept.
- wdata  in  DATA_W  write data; sampled on accept, ignored for reads.
- rdata  out  DATA_W  read data; valid from the done pulse onward.
- done  out  1  one-cycle pulse at the end of every transaction.
- busy  out  1  high from accept until done inclusive.
- sclk  out  1  SPI clock, idles low.
- cs_n  out  1  chip select, active low.
- mosi  out  1  serial data to target.
- miso  in  1  serial data from target.

Behaviour:
- Reset (synchronous, rst_n=0 at a clk edge):
  - cs_n=1, sclk=0, mosi=0, done=0, busy=0, rdata=0, start_ready=1.
  - State returns to IDLE and all counters clear.
  - Reset mid-frame aborts immediately; no done pulse is issued.
- Accept: on a clk edge with start_valid & start_ready, latch the frame.
  - frame = {rw, (7-ADDR_W) zeros, addr, wdata} for writes.
  - frame = {rw, zeros, addr, 8'h00} for reads; MOSI carries zeros during the data byte.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - start_ready=1, cs_n=1, sclk=0.
  - On accept, go to SETUP; busy rises in the next cycle.
- SETUP:
  - H cycles long; cs_n=0, sclk=0, mosi=frame[15].
- SHIFT:
  - 16 bit periods of 2H cycles each: sclk=1 for H cycles, then sclk=0 for H cycles.
  - MISO is sampled on the last clk cycle of each high phase and shifted into rx[0].
  - mosi advances to the next frame bit when sclk falls.
  - After the 16th high phase, sclk returns low and the state moves to HOLD. No 17th edge is issued.
- HOLD:
  - H cycles; cs_n=0, sclk=0.
- Completion, on the cycle cs_n returns to 1:
  - done=1 for exactly one cycle.
  - For reads, rdata is loaded with the last 8 sampled bits (rx[7:0]). For writes, rdata is unchanged.
  - busy falls the cycle after done.
- GAP:
  - H cycles with cs_n=1 (minimum deselect time), then IDLE.
  - start_ready is 0 throughout.
- Timing: cs_n is low for exactly 34H clk cycles. Accept-to-done latency is 34H+1 cycles.
- Back-to-back: start_valid held high is accepted on the first IDLE cycle, so accept-to-accept = 35H+2 cycles.
- start_valid while not ready is ignored. Input fields are not re-sampled mid-frame.
- miso is treated as synchronous to clk; the target drives it from sclk falling edges, and the sample point satisfies mode 0.
- sclk, cs_n and mosi are driven directly from flops (glitch-free).

Decomposition:
- Package spi_pkg:
  - state enum (IDLE, SETUP, SHIFT, HOLD, GAP).
  - FRAME_W=16, CMD_RW_BIT=15.
  - Default constants for CLK_DIV, ADDR_W and DATA_W.
- Sub-module spi_sclk_div:
  - Half-period counter with an enable input.
  - Outputs a one-cycle tick every H cycles and a phase bit.
  - Used by spi_master for both SCLK generation and SETUP/HOLD/GAP timing.

Test Plan:
- Reset check: assert rst_n=0 mid-SHIFT (bit 5) -> next cycle cs_n=1, sclk=0, mosi=0, busy=0, start_ready=1; no done pulse.
- Write: rw=1, addr=4'hA, wdata=8'h5C, CLK_DIV=4 -> MOSI bit stream 1000_1010_0101_1100, sampled on each of 16 sclk rising edges; cs_n low for 136 cycles; done at accept+137; rdata unchanged.
- Read: model target returns 8'hC3 on data byte, rw=0, addr=4'h3 -> MOSI 0000_0011_0000_0000; rdata=8'hC3 with done.
- Write-then-read round trip: write 8'hFF to addr 0, then read addr 0 via the memory-backed SPI target model -> rdata=8'hFF.
- Handshake: hold start_valid=1 with two commands queued -> second accepted exactly 35H+2 cycles after first; start_ready=0 throughout, including GAP; no pulse on sclk while cs_n=1.
- Divider corner: CLK_DIV=2 -> sclk period 4 cycles, cs_n low 68 cycles, read of 8'h81 returns 8'h81 (checks MSB/LSB sample edges).
